// File: rtl/raster_sequencer.sv
// raster_sequencer: runs one draw/clear op from the CSR through the raster/clear engines
module raster_sequencer #(
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] csr_in,
  input  logic [63:0] vertex_a_in,
  input  logic [63:0] vertex_b_in,
  input  logic [63:0] vertex_c_in,
  input  logic [63:0] back_colour_in,
  output logic [5:0]  control_bit_address,
  output logic        control_bit_load,
  output logic        control_bit_in,
  input  logic        control_bit_out,
  output logic [63:0] vtx_a_q,
  output logic [63:0] vtx_b_q,
  output logic [63:0] vtx_c_q,
  output logic [31:0] colour_q,
  output logic        raster_start,
  input  logic        raster_done,
  output logic        clear_start,
  input  logic        clear_done,
  output logic        irq
);
  typedef enum logic [3:0] {IDLE, SNAP, SET_BUSY, CLR_DONE, KICK, WAIT, WR_DONE, CLR_START, CLR_BUSY} state_t;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t state_q, state_d;
  logic op_q, op_d, sub_q, sub_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [63:0] vtx_a_d, vtx_b_d, vtx_c_d;
  logic [31:0] colour_d;
  logic load_q, load_d, bit_q, bit_d, retry_q, retry_d;
  logic [5:0] addr_q, addr_d;
  logic raster_start_q, raster_start_d, clear_start_q, clear_start_d;
  logic chk_q, chk_bit_q, chk_retry_q;
  logic [5:0] chk_addr_q;
  logic mismatch, done, unused;
  assign control_bit_address = addr_q;
  assign control_bit_load = load_q;
  assign control_bit_in = bit_q;
  assign raster_start = raster_start_q;
  assign clear_start = clear_start_q;
  assign irq = csr_in[4] & (csr_in[2] | csr_in[5]);
  assign unused = ^{csr_in[63:6], csr_in[1], back_colour_in[63:32]};
  // Read-back arrives the cycle after a write; a first-time mismatch re-issues it while the FSM holds.
  assign mismatch = chk_q && !chk_retry_q && (control_bit_out != chk_bit_q);
  assign done = op_q ? clear_done : raster_done;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sub_d = sub_q;
    wd_d = wd_q;
    vtx_a_d = vtx_a_q;
    vtx_b_d = vtx_b_q;
    vtx_c_d = vtx_c_q;
    colour_d = colour_q;
    {load_d, addr_d, bit_d, retry_d} = {1'b0, addr_q, bit_q, 1'b0};
    raster_start_d = 1'b0;
    clear_start_d = 1'b0;
    if (mismatch) {load_d, addr_d, bit_d, retry_d} = {1'b1, chk_addr_q, chk_bit_q, 1'b1};
    else case (state_q)
      IDLE: if (csr_in[3] || csr_in[0]) begin
        op_d = csr_in[3];
        state_d = SNAP;
      end
      SNAP: begin
        {vtx_a_d, vtx_b_d, vtx_c_d, colour_d} = {vertex_a_in, vertex_b_in, vertex_c_in, back_colour_in[31:0]};
        state_d = SET_BUSY;
        {load_d, addr_d, bit_d} = {1'b1, 6'd1, 1'b1};
      end
      SET_BUSY: begin
        state_d = CLR_DONE;
        sub_d = 1'b0;
        {load_d, addr_d, bit_d} = {1'b1, 6'd2, 1'b0};
      end
      CLR_DONE: if (!sub_q) begin
        sub_d = 1'b1;
        {load_d, addr_d, bit_d} = {1'b1, 6'd5, 1'b0};
      end else begin
        state_d = KICK;
        raster_start_d = !op_q;
        clear_start_d = op_q;
      end
      KICK: begin
        state_d = WAIT;
        wd_d = '0;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (done || wd_q == WD_LAST) begin
          state_d = WR_DONE;
          {load_d, addr_d, bit_d} = {1'b1, done ? 6'd2 : 6'd5, 1'b1};
        end
      end
      WR_DONE: begin
        state_d = CLR_START;
        {load_d, addr_d, bit_d} = {1'b1, op_q ? 6'd3 : 6'd0, 1'b0};
      end
      CLR_START: begin
        state_d = CLR_BUSY;
        {load_d, addr_d, bit_d} = {1'b1, 6'd1, 1'b0};
      end
      CLR_BUSY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      {op_q, sub_q, wd_q} <= '0;
      {vtx_a_q, vtx_b_q, vtx_c_q, colour_q} <= '0;
      {load_q, addr_q, bit_q, retry_q} <= '0;
      {raster_start_q, clear_start_q} <= '0;
      {chk_q, chk_addr_q, chk_bit_q, chk_retry_q} <= '0;
    end else begin
      state_q <= state_d;
      {op_q, sub_q, wd_q} <= {op_d, sub_d, wd_d};
      {vtx_a_q, vtx_b_q, vtx_c_q, colour_q} <= {vtx_a_d, vtx_b_d, vtx_c_d, colour_d};
      {load_q, addr_q, bit_q, retry_q} <= {load_d, addr_d, bit_d, retry_d};
      {raster_start_q, clear_start_q} <= {raster_start_d, clear_start_d};
      {chk_q, chk_addr_q, chk_bit_q, chk_retry_q} <= {load_q, addr_q, bit_q, retry_q};
    end
  end
endmodule

// File: tb/tb_raster_sequencer.sv
// tb_raster_sequencer: directed bench with a bit-addressable CSR model and a write log
module tb_raster_sequencer;
  logic clk = 1'b0, reset = 1'b0;
  logic [63:0] csr_in = '0, vertex_a_in, vertex_b_in, vertex_c_in, back_colour_in;
  logic [5:0] control_bit_address;
  logic control_bit_load, control_bit_in, control_bit_out = 1'b0;
  logic [63:0] vtx_a_q, vtx_b_q, vtx_c_q;
  logic [31:0] colour_q;
  logic raster_start, raster_done = 1'b0, clear_start, clear_done = 1'b0, irq;
  int ncmp = 0, nerr = 0, nw = 0, flip_n = 0, n, nw_save;
  logic [41:0] wlog = '0;
  logic rs_seen = 1'b0, cs_seen = 1'b0;
  localparam logic [41:0] DRAW_LOG = {6'd1, 1'b1, 6'd2, 1'b0, 6'd5, 1'b0, 6'd2, 1'b1, 6'd0, 1'b0, 6'd1, 1'b0};
  localparam logic [41:0] CLR_LOG  = {6'd1, 1'b1, 6'd2, 1'b0, 6'd5, 1'b0, 6'd2, 1'b1, 6'd3, 1'b0, 6'd1, 1'b0};
  localparam logic [41:0] TO_LOG   = {6'd1, 1'b1, 6'd2, 1'b0, 6'd5, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd1, 1'b0};
  localparam logic [27:0] RETRY_LOG = {6'd1, 1'b1, 6'd2, 1'b0, 6'd1, 1'b1, 6'd5, 1'b0};

  raster_sequencer #(.TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .csr_in(csr_in),
    .vertex_a_in(vertex_a_in), .vertex_b_in(vertex_b_in), .vertex_c_in(vertex_c_in),
    .back_colour_in(back_colour_in),
    .control_bit_address(control_bit_address), .control_bit_load(control_bit_load),
    .control_bit_in(control_bit_in), .control_bit_out(control_bit_out),
    .vtx_a_q(vtx_a_q), .vtx_b_q(vtx_b_q), .vtx_c_q(vtx_c_q), .colour_q(colour_q),
    .raster_start(raster_start), .raster_done(raster_done),
    .clear_start(clear_start), .clear_done(clear_done), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record this cycle's outputs, then commit any bit write into the CSR model.
  task automatic step();
    logic ld, d, fl;
    logic [5:0] a;
    ld = control_bit_load;
    a = control_bit_address;
    d = control_bit_in;
    rs_seen = rs_seen | raster_start;
    cs_seen = cs_seen | clear_start;
    @(posedge clk);
    #1;
    if (ld) begin
      csr_in[a] = d;
      wlog = {wlog[34:0], a, d};
      nw++;
      fl = (a == 6'd1) && d && (flip_n > 0);
      control_bit_out = d ^ fl;
      if (fl) flip_n--;
    end
  endtask

  task automatic wait_start(input logic clr, output int cnt);
    cnt = 0;
    while (!(clr ? clear_start : raster_start) && cnt < 40) begin
      step();
      cnt++;
    end
  endtask

  task automatic new_op(input logic [63:0] csr);
    csr_in = csr;
    wlog = '0;
    nw = 0;
    rs_seen = 1'b0;
    cs_seen = 1'b0;
  endtask

  initial begin
    vertex_a_in = 64'h1111;
    vertex_b_in = 64'h3333;
    vertex_c_in = 64'h5555;
    back_colour_in = 64'hAABBCCDD_EEFF0011;
    step();
    step();
    check("reset_load", control_bit_load, 0);
    check("reset_start", raster_start, 0);
    check("reset_vtx_a", vtx_a_q, 0);
    check("reset_irq", irq, 0);
    reset = 1'b1;
    step();

    new_op(64'h1);
    wait_start(1'b0, n);
    check("draw_latency", n, 5);
    check("draw_vtx_a", vtx_a_q, 64'h1111);
    check("draw_vtx_c", vtx_c_q, 64'h5555);
    repeat (10) step();
    raster_done = 1'b1;
    step();
    raster_done = 1'b0;
    step();
    step();
    check("draw_busy_clr_cycle", {control_bit_load, control_bit_address, control_bit_in}, {1'b1, 6'd1, 1'b0});
    repeat (3) step();
    check("draw_log", wlog, DRAW_LOG);
    check("draw_nwrites", nw, 6);
    check("draw_csr", csr_in, 64'h4);
    check("draw_irq", irq, 0);

    new_op(64'h9);
    wait_start(1'b1, n);
    check("clear_latency", n, 5);
    check("clear_no_raster", rs_seen, 0);
    repeat (3) step();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    repeat (3) step();
    check("clear_log", wlog, CLR_LOG);
    check("clear_bit3", csr_in[3], 0);
    wait_start(1'b0, n);
    check("pending_draw_latency", n, 5);
    repeat (2) step();
    raster_done = 1'b1;
    step();
    raster_done = 1'b0;
    repeat (4) step();
    check("pending_draw_csr", csr_in, 64'h4);

    new_op(64'h11);
    wait_start(1'b0, n);
    vertex_a_in = 64'h2222;
    repeat (16) step();
    check("timeout_err_write", {control_bit_load, control_bit_address, control_bit_in}, {1'b1, 6'd5, 1'b1});
    repeat (3) step();
    check("timeout_log", wlog, TO_LOG);
    check("timeout_csr", csr_in, 64'h30);
    check("timeout_irq", irq, 1);
    check("snap_vtx_a", vtx_a_q, 64'h1111);
    check("snap_colour", colour_q, 64'hEEFF0011);
    csr_in = 64'h14;
    #1 check("irq_done_en", irq, 1);
    csr_in = 64'h04;
    #1 check("irq_no_en", irq, 0);

    vertex_a_in = 64'h4444;
    new_op(64'h1);
    wait_start(1'b0, n);
    repeat (15) step();
    raster_done = 1'b1;
    step();
    raster_done = 1'b0;
    check("race_done_write", {control_bit_load, control_bit_address, control_bit_in}, {1'b1, 6'd2, 1'b1});
    repeat (3) step();
    check("race_log", wlog, DRAW_LOG);
    check("race_err_bit", csr_in[5], 0);
    check("resnap_vtx_a", vtx_a_q, 64'h4444);

    new_op(64'h1);
    flip_n = 2;
    wait_start(1'b0, n);
    check("retry_latency", n, 6);
    check("retry_log", wlog[27:0], RETRY_LOG);
    repeat (2) step();
    raster_done = 1'b1;
    step();
    raster_done = 1'b0;
    repeat (4) step();
    check("retry_nwrites", nw, 7);
    check("retry_flips_used", flip_n, 0);

    new_op(64'h1);
    wait_start(1'b0, n);
    repeat (3) step();
    reset = 1'b0;
    csr_in = '0;
    #1;
    check("rst_load", control_bit_load, 0);
    check("rst_addr", control_bit_address, 0);
    check("rst_vtx_a", vtx_a_q, 0);
    check("rst_colour", colour_q, 0);
    step();
    step();
    reset = 1'b1;
    nw_save = nw;
    rs_seen = 1'b0;
    raster_done = 1'b1;
    step();
    raster_done = 1'b0;
    repeat (6) step();
    check("rst_late_done_nowrite", nw, nw_save);
    check("rst_no_restart", rs_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
